// File: rtl/mux_pkg.sv
// Shared definitions for the 4:1 TDM path: slot numbering (same encoding as the
// multiplexer select) and the demultiplexer lock state.
package mux_pkg;

    localparam logic [1:0] SLOT0 = 2'b00;
    localparam logic [1:0] SLOT1 = 2'b01;
    localparam logic [1:0] SLOT2 = 2'b10;
    localparam logic [1:0] SLOT3 = 2'b11;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/tdm_demultiplexer_if.sv
// Serial-in / parallel-out bundle of the TDM demultiplexer.
// The master drives the serial lane; the slave is the demultiplexer itself.
interface tdm_demultiplexer_if #(
    parameter int W = 1
);
    logic [W-1:0] in;
    logic         en;
    logic         sync;
    logic [W-1:0] o0;
    logic [W-1:0] o1;
    logic [W-1:0] o2;
    logic [W-1:0] o3;
    logic         s0;
    logic         s1;
    logic         frame_done;
    logic         sync_err;

    modport master (
        output in, en, sync,
        input  o0, o1, o2, o3, s0, s1, frame_done, sync_err
    );

    modport slave (
        input  in, en, sync,
        output o0, o1, o2, o3, s0, s1, frame_done, sync_err
    );
endinterface

// File: rtl/demux_slot_ctr.sv
// Slot counter for the TDM demultiplexer: tracks lock state and the index of the
// next accepted sample, wrapping modulo 4 once locked.
module demux_slot_ctr (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic       i_sync,
    output logic [1:0] o_slot,
    output logic       o_last,
    output logic       o_locked
);
    import mux_pkg::*;

    logic [0:0] r_state;
    logic [1:0] r_slot;

    // A sync always restarts the frame at slot 1; unlocked samples never advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_slot  <= SLOT0;
        end else if (i_en) begin
            if (i_sync) begin
                r_state <= ST_RUN;
                r_slot  <= SLOT1;
            end else if (r_state == ST_RUN) begin
                r_slot <= r_slot + 2'd1;
            end
        end
    end

    assign o_slot   = r_slot;
    assign o_last   = (r_slot == SLOT3);
    assign o_locked = (r_state == ST_RUN);

endmodule

// File: rtl/tdm_demultiplexer.sv
// Registered 1-to-4 TDM demultiplexer: gathers slots 0..2 in shadow registers and
// publishes a whole frame at once when slot 3 arrives.
module tdm_demultiplexer #(
    parameter int W = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    tdm_demultiplexer_if.slave   bus
);
    import mux_pkg::*;

    logic [1:0]   w_slot;
    logic         w_last;
    logic         w_locked;

    logic [W-1:0] r_sh0;
    logic [W-1:0] r_sh1;
    logic [W-1:0] r_sh2;
    logic [W-1:0] r_o0;
    logic [W-1:0] r_o1;
    logic [W-1:0] r_o2;
    logic [W-1:0] r_o3;
    logic         r_frame_done;
    logic         r_sync_err;

    demux_slot_ctr u_slot_ctr (
        .clk      (clk),
        .rst      (rst),
        .i_en     (bus.en),
        .i_sync   (bus.sync),
        .o_slot   (w_slot),
        .o_last   (w_last),
        .o_locked (w_locked)
    );

    // Outputs only ever move as a full frame; a sync mid-frame drops the shadows' meaning.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh0        <= '0;
            r_sh1        <= '0;
            r_sh2        <= '0;
            r_o0         <= '0;
            r_o1         <= '0;
            r_o2         <= '0;
            r_o3         <= '0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
            if (bus.en) begin
                if (bus.sync) begin
                    r_sh0      <= bus.in;
                    r_sync_err <= w_locked && (w_slot != SLOT0);
                end else if (w_locked) begin
                    if (w_last) begin
                        r_o0         <= r_sh0;
                        r_o1         <= r_sh1;
                        r_o2         <= r_sh2;
                        r_o3         <= bus.in;
                        r_frame_done <= 1'b1;
                    end else begin
                        case (w_slot)
                            SLOT0:   r_sh0 <= bus.in;
                            SLOT1:   r_sh1 <= bus.in;
                            default: r_sh2 <= bus.in;
                        endcase
                    end
                end
            end
        end
    end

    assign bus.o0         = r_o0;
    assign bus.o1         = r_o1;
    assign bus.o2         = r_o2;
    assign bus.o3         = r_o3;
    assign bus.s0         = w_slot[0];
    assign bus.s1         = w_slot[1];
    assign bus.frame_done = r_frame_done;
    assign bus.sync_err   = r_sync_err;

endmodule

// File: tb/tb_tdm_demultiplexer.sv
// Directed self-checking bench for tdm_demultiplexer (W=1): each step drives one
// cycle of lane inputs and compares the registered outputs against hand-computed values.
module tb_tdm_demultiplexer;

    localparam int W = 1;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    tdm_demultiplexer_if #(.W(W)) bus ();

    tdm_demultiplexer #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs at the falling edge, then settle just past the rising edge.
    task automatic applyStimulus(input logic e, input logic s, input logic [W-1:0] d);
        @(negedge clk);
        bus.en   = e;
        bus.sync = s;
        bus.in   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] expO, input logic [1:0] expS,
                               input logic expFd, input logic expSe);
        logic [3:0] obsO;
        logic [1:0] obsS;
        obsO = {bus.o3[0], bus.o2[0], bus.o1[0], bus.o0[0]};
        obsS = {bus.s1, bus.s0};
        checks++;
        assert (obsO === expO) else begin
            errors++;
            $error("FAIL %s outputs o3..o0 observed %b expected %b", tag, obsO, expO);
        end
        checks++;
        assert (obsS === expS) else begin
            errors++;
            $error("FAIL %s slot s1s0 observed %b expected %b", tag, obsS, expS);
        end
        checks++;
        assert (bus.frame_done === expFd) else begin
            errors++;
            $error("FAIL %s frame_done observed %b expected %b", tag, bus.frame_done, expFd);
        end
        checks++;
        assert (bus.sync_err === expSe) else begin
            errors++;
            $error("FAIL %s sync_err observed %b expected %b", tag, bus.sync_err, expSe);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        bus.en   = 1'b0;
        bus.sync = 1'b0;
        bus.in   = '0;

        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("reset", 4'b0000, 2'b00, 1'b0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            checkOutput("idle_en_low", 4'b0000, 2'b00, 1'b0, 1'b0);
        end

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1);
            checkOutput("idle_unsynced", 4'b0000, 2'b00, 1'b0, 1'b0);
        end

        // Synced frame 1,0,0,0
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("f1_slot0", 4'b0000, 2'b01, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("f1_slot1", 4'b0000, 2'b10, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("f1_slot2", 4'b0000, 2'b11, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("f1_done", 4'b0001, 2'b00, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("f1_pulse_end", 4'b0001, 2'b00, 1'b0, 1'b0);

        // Unsynced follow-on frame 0,1,0,0
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("f2_slot0", 4'b0001, 2'b01, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("f2_slot1", 4'b0001, 2'b10, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("f2_slot2", 4'b0001, 2'b11, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("f2_done", 4'b0010, 2'b00, 1'b1, 1'b0);

        // Sync at slot 0 is legal; frame 0,0,1,1 with a 3-cycle gap after slot 1
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("f3_sync_at_slot0", 4'b0010, 2'b01, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("f3_slot1", 4'b0010, 2'b10, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            checkOutput("f3_gap", 4'b0010, 2'b10, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("f3_slot2", 4'b0010, 2'b11, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("f3_done", 4'b1100, 2'b00, 1'b1, 1'b0);

        // Resync after two samples: partial frame dropped, new frame 0,1,0,1
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("f4_slot0", 4'b1100, 2'b01, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("f4_slot1", 4'b1100, 2'b10, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("f5_resync_err", 4'b1100, 2'b01, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("f5_slot1", 4'b1100, 2'b10, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("f5_slot2", 4'b1100, 2'b11, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("f5_done", 4'b1010, 2'b00, 1'b1, 1'b0);

        // Reset mid-frame at slot 2 returns to IDLE
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("f6_slot0", 4'b1010, 2'b01, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("f6_slot1", 4'b1010, 2'b10, 1'b0, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("mid_reset", 4'b0000, 2'b00, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1);
            checkOutput("post_reset_unsynced", 4'b0000, 2'b00, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
